es_led_writer: RTL and testbench

Avalon-MM master that drives the bank of 7-bit LED/seven-segment PIO slaves in the ES system. Accepts hex-digit display requests over a valid/ready port, encodes each digit to a segment pattern, and issues one single-beat write to the addressed PIO's data register. Optionally reads the register back and checks it, reporting status per request. Sits between control logic (or a soft-CPU-side FIFO) and the system interconnect, as the initiator for the PIO responders.

---
 rtl/es_led_pkg.sv | 19 +
 rtl/es_led_writer_if.sv | 22 ++
 rtl/es_hex2seg.sv | 19 +
 rtl/es_led_writer.sv | 144 ++++++++++++++
 tb/tb_es_led_writer.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/es_led_pkg.sv
// Shared types and constants for the ES LED/seven-segment PIO writer.
package es_led_pkg;

    typedef enum logic [2:0] {StIdle, StWr, StRd, StRdv, StDone} state_e;

    typedef logic [1:0] status_t;

    localparam status_t ST_OK       = 2'd0;
    localparam status_t ST_RANGE    = 2'd1;
    localparam status_t ST_MISMATCH = 2'd2;
    localparam status_t ST_TIMEOUT  = 2'd3;

    // Active-high segments, bit0 = a ... bit6 = g, indexed by hex digit.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/es_led_writer_if.sv
// Avalon-MM bus bundle between the LED writer (master) and the PIO interconnect (slave).
interface es_led_writer_if;

    logic [31:0] avm_address;
    logic        avm_write;
    logic        avm_read;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        avm_readdatavalid;

    modport master (
        output avm_address, avm_write, avm_read, avm_writedata,
        input  avm_readdata, avm_waitrequest, avm_readdatavalid
    );

    modport slave (
        input  avm_address, avm_write, avm_read, avm_writedata,
        output avm_readdata, avm_waitrequest, avm_readdatavalid
    );

endinterface

// File: rtl/es_hex2seg.sv
// Hex digit to 7-segment pattern encoder with blanking and optional inversion.
module es_hex2seg
    import es_led_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] value,
    input  logic       blank,
    output logic [6:0] seg
);

    logic [6:0] lit;

    always_comb begin
        lit = blank ? 7'h00 : SEG_TABLE[value];
        seg = ACTIVE_LOW ? ~lit : lit;
    end

endmodule

// File: rtl/es_led_writer.sv
// Avalon-MM master: encodes a hex digit, writes it to the addressed LED PIO and
// optionally reads it back, reporting a status code per request.
module es_led_writer
    import es_led_pkg::*;
#(
    parameter int unsigned DIGITS     = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
    parameter logic [31:0] STRIDE     = 32'h10,
    parameter bit          ACTIVE_LOW = 1'b1,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_digit,
    input  logic [3:0]      req_value,
    input  logic            req_blank,
    input  logic            req_verify,

    output logic            done,
    output logic [1:0]      status,

    es_led_writer_if.master avm
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_e      state_q;
    logic        req_ready_q;
    logic        write_q;
    logic        read_q;
    logic        done_q;
    status_t     status_q;
    logic [31:0] addr_q;
    logic [3:0]  value_q;
    logic        blank_q;
    logic        verify_q;
    logic [7:0]  tmo_q;
    logic [6:0]  pattern;
    logic        rd_match;

    es_hex2seg #(
        .ACTIVE_LOW(ACTIVE_LOW)
    ) u_hex2seg (
        .value(value_q),
        .blank(blank_q),
        .seg  (pattern)
    );

    assign rd_match = (avm.avm_readdata == {25'b0, pattern});

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            req_ready_q <= 1'b1;
            write_q     <= 1'b0;
            read_q      <= 1'b0;
            done_q      <= 1'b0;
            status_q    <= ST_OK;
            addr_q      <= '0;
            value_q     <= '0;
            blank_q     <= 1'b0;
            verify_q    <= 1'b0;
            tmo_q       <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        value_q     <= req_value;
                        blank_q     <= req_blank;
                        verify_q    <= req_verify;
                        addr_q      <= BASE_ADDR + 32'(req_digit) * STRIDE;
                        req_ready_q <= 1'b0;
                        if (32'(req_digit) >= DIGITS) begin
                            state_q  <= StDone;
                            done_q   <= 1'b1;
                            status_q <= ST_RANGE;
                        end else begin
                            state_q <= StWr;
                            write_q <= 1'b1;
                        end
                    end
                end
                StWr: begin
                    if (!avm.avm_waitrequest) begin
                        write_q <= 1'b0;
                        if (verify_q) begin
                            state_q <= StRd;
                            read_q  <= 1'b1;
                        end else begin
                            state_q  <= StDone;
                            done_q   <= 1'b1;
                            status_q <= ST_OK;
                        end
                    end
                end
                StRd: begin
                    if (!avm.avm_waitrequest) begin
                        read_q  <= 1'b0;
                        tmo_q   <= '0;
                        state_q <= StRdv;
                    end
                end
                StRdv: begin
                    // Data arriving on the last allowed cycle still wins over the timeout.
                    if (avm.avm_readdatavalid) begin
                        state_q  <= StDone;
                        done_q   <= 1'b1;
                        status_q <= rd_match ? ST_OK : ST_MISMATCH;
                    end else if (tmo_q == TMO_LAST) begin
                        state_q  <= StDone;
                        done_q   <= 1'b1;
                        status_q <= ST_TIMEOUT;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end
                StDone: begin
                    state_q     <= StIdle;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= StIdle;
                    req_ready_q <= 1'b1;
                    write_q     <= 1'b0;
                    read_q      <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready         = req_ready_q;
    assign done              = done_q;
    assign status            = status_q;
    assign avm.avm_address   = addr_q;
    assign avm.avm_write     = write_q;
    assign avm.avm_read      = read_q;
    // Data bus is only driven while a write is in flight, so it reads zero after reset.
    assign avm.avm_writedata = write_q ? {25'b0, pattern} : 32'h0;

endmodule

// File: tb/tb_es_led_writer.sv
// Scoreboard bench for es_led_writer with a stall/latency-programmable PIO responder.
module tb_es_led_writer;

    localparam int unsigned DIGITS = 6;
    localparam logic [31:0] BASE   = 32'h0000_1000;
    localparam logic [31:0] STR    = 32'h10;
    localparam int unsigned TMO    = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_digit;
    logic [3:0] req_value;
    logic       req_blank;
    logic       req_verify;
    logic       done;
    logic [1:0] status;

    es_led_writer_if avm ();

    es_led_writer #(
        .DIGITS    (DIGITS),
        .BASE_ADDR (BASE),
        .STRIDE    (STR),
        .ACTIVE_LOW(1'b1),
        .TIMEOUT   (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_digit (req_digit),
        .req_value (req_value),
        .req_blank (req_blank),
        .req_verify(req_verify),
        .done      (done),
        .status    (status),
        .avm       (avm)
    );

    always #5 clk = ~clk;

    typedef struct {logic [1:0] st; int cyc;} done_t;
    typedef struct {logic [31:0] addr; logic [31:0] data;} wr_t;

    done_t       done_q[$];
    wr_t         wr_q[$];
    logic [31:0] rd_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Responder plan for the request in flight.
    int          cur_ws = 0;
    int          cur_rs = 0;
    int          cur_d = 0;
    bit          cur_respond = 1'b1;
    logic [31:0] cur_rdata = '0;

    logic [6:0] seg_tab [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] ref_pattern(input logic [3:0] v, input logic b);
        logic [6:0] p;
        p = b ? 7'h00 : seg_tab[v];
        return ~p;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Bus responder and write/read checker, evaluated mid-cycle.
    int wcnt = 0;
    int rcnt = 0;
    int dcnt = 0;
    bit pend = 1'b0;
    always @(negedge clk) begin : bus
        wr_t         w;
        logic [31:0] ra;
        avm.avm_readdatavalid = 1'b0;
        if (reset) begin
            wcnt = 0;
            rcnt = 0;
            pend = 1'b0;
            avm.avm_waitrequest = 1'b0;
        end else begin
            check("no_rw_overlap", 32'(avm.avm_write & avm.avm_read), 32'h0);
            if (pend) begin
                if (dcnt == 0) begin
                    avm.avm_readdatavalid = 1'b1;
                    avm.avm_readdata = cur_rdata;
                    pend = 1'b0;
                end else begin
                    dcnt--;
                end
            end
            if (avm.avm_write) begin
                if (wr_q.size() == 0) begin
                    avm.avm_waitrequest = (wcnt < cur_ws);
                    if (wcnt < cur_ws) wcnt++;
                    else begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h", avm.avm_address,
                                 avm.avm_writedata);
                        wcnt = 0;
                    end
                end else begin
                    w = wr_q[0];
                    check("wr_addr", avm.avm_address, w.addr);
                    check("wr_data", avm.avm_writedata, w.data);
                    if (wcnt < cur_ws) begin
                        avm.avm_waitrequest = 1'b1;
                        wcnt++;
                    end else begin
                        avm.avm_waitrequest = 1'b0;
                        wcnt = 0;
                        void'(wr_q.pop_front());
                    end
                end
            end else if (avm.avm_read) begin
                if (rcnt < cur_rs) begin
                    avm.avm_waitrequest = 1'b1;
                    rcnt++;
                end else begin
                    avm.avm_waitrequest = 1'b0;
                    rcnt = 0;
                    if (rd_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_read: addr 0x%0h", avm.avm_address);
                    end else begin
                        ra = rd_q.pop_front();
                        check("rd_addr", avm.avm_address, ra);
                    end
                    if (cur_respond) begin
                        pend = 1'b1;
                        dcnt = cur_d;
                    end
                end
            end else begin
                avm.avm_waitrequest = 1'b0;
            end
        end
    end

    // Completion monitor.
    always @(negedge clk) begin : mon
        done_t e;
        if (!reset && done) begin
            if (done_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: status %0d (cycle %0d)", status, cyc);
            end else begin
                e = done_q.pop_front();
                check("status", 32'(status), 32'(e.st));
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic issue(input logic [2:0] dg, input logic [3:0] v, input logic b,
                         input logic vf, input int ws, input int rs, input int d,
                         input bit resp, input logic [31:0] rdata);
        done_t      e;
        wr_t        w;
        int         lat;
        int         guard;
        logic [6:0] p;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_req", 32'(req_ready), 32'h1);
        cur_ws = ws;
        cur_rs = rs;
        cur_d = d;
        cur_respond = resp;
        cur_rdata = rdata;
        p = ref_pattern(v, b);
        if (32'(dg) >= DIGITS) begin
            e.st = 2'd1;
            lat = 1;
        end else begin
            w.addr = BASE + 32'(dg) * STR;
            w.data = {25'b0, p};
            wr_q.push_back(w);
            if (!vf) begin
                e.st = 2'd0;
                lat = 2 + ws;
            end else begin
                rd_q.push_back(w.addr);
                if (!resp || d >= int'(TMO)) begin
                    e.st = 2'd3;
                    lat = 3 + ws + rs + int'(TMO);
                end else begin
                    e.st = (rdata == {25'b0, p}) ? 2'd0 : 2'd2;
                    lat = 4 + ws + rs + d;
                end
            end
        end
        e.cyc = cyc + lat;
        done_q.push_back(e);
        req_digit = dg;
        req_value = v;
        req_blank = b;
        req_verify = vf;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        req_digit = 3'($urandom);
        req_value = 4'($urandom);
        guard = 0;
        while (!done && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL done_wait: no done within bound (cycle %0d)", cyc);
        end
        @(negedge clk);
        check("ready_after_done", 32'(req_ready), 32'h1);
        check("status_hold", 32'(status), 32'(e.st));
        check("done_single", 32'(done), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        logic [6:0]  p;
        logic [31:0] rdata;
        int          kind;
        int          d;
        bit          resp;
        reset = 1'b1;
        req_valid = 1'b0;
        req_digit = '0;
        req_value = '0;
        req_blank = 1'b0;
        req_verify = 1'b0;
        avm.avm_waitrequest = 1'b0;
        avm.avm_readdatavalid = 1'b0;
        avm.avm_readdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'h1);
        check("rst_write", 32'(avm.avm_write), 32'h0);
        check("rst_read", 32'(avm.avm_read), 32'h0);
        check("rst_addr", avm.avm_address, 32'h0);
        check("rst_wdata", avm.avm_writedata, 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_status", 32'(status), 32'h0);

        // Directed cases.
        issue(3'd2, 4'hA, 1'b0, 1'b0, 0, 0, 0, 1'b1, 32'h0);
        issue(3'd0, 4'h8, 1'b0, 1'b1, 3, 0, 0, 1'b1, 32'h0);
        issue(3'd1, 4'h0, 1'b0, 1'b1, 0, 0, 0, 1'b1, 32'h0000_0001);
        issue(3'd1, 4'h0, 1'b0, 1'b1, 0, 0, 0, 1'b1, 32'h8000_0040);
        issue(3'd3, 4'h5, 1'b0, 1'b1, 1, 2, int'(TMO) + 2, 1'b1, {25'b0, ref_pattern(4'h5, 1'b0)});
        issue(3'd4, 4'h5, 1'b0, 1'b1, 0, 0, int'(TMO) - 1, 1'b1, {25'b0, ref_pattern(4'h5, 1'b0)});
        issue(3'd5, 4'hF, 1'b1, 1'b1, 0, 1, 1, 1'b1, 32'h0000_007F);
        issue(3'(DIGITS), 4'h3, 1'b0, 1'b1, 0, 0, 0, 1'b1, 32'h0);
        issue(3'd7, 4'h3, 1'b0, 1'b0, 0, 0, 0, 1'b1, 32'h0);

        // Reset while a write is stalled.
        cur_ws = 1000;
        req_digit = 3'd1;
        req_value = 4'h3;
        req_blank = 1'b0;
        req_verify = 1'b0;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("stalled_write", 32'(avm.avm_write), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_write", 32'(avm.avm_write), 32'h0);
        check("midrst_ready", 32'(req_ready), 32'h1);
        check("midrst_done", 32'(done), 32'h0);
        reset = 1'b0;
        cur_ws = 0;
        repeat (2) @(negedge clk);
        issue(3'd1, 4'h3, 1'b0, 1'b1, 0, 0, 0, 1'b1, {25'b0, ref_pattern(4'h3, 1'b0)});

        // Randomized requests.
        for (int i = 0; i < 40; i++) begin
            logic [2:0] dg;
            logic [3:0] v;
            logic       b;
            dg = 3'($urandom_range(0, 7));
            v = 4'($urandom);
            b = ($urandom_range(0, 5) == 0);
            p = ref_pattern(v, b);
            kind = $urandom_range(0, 9);
            resp = (kind != 0);
            d = (kind == 1) ? int'(TMO) + 2 : (kind == 2) ? int'(TMO) - 1 : $urandom_range(0, 4);
            rdata = {25'b0, p};
            if ($urandom_range(0, 3) == 0) rdata = rdata ^ (32'h1 << $urandom_range(0, 31));
            issue(dg, v, b, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3),
                  d, resp, rdata);
        end

        repeat (4) @(negedge clk);
        check("wr_q_empty", 32'(wr_q.size()), 32'h0);
        check("rd_q_empty", 32'(rd_q.size()), 32'h0);
        check("done_q_empty", 32'(done_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
